// File: rtl/spi_flash_responder.sv
// SPI NOR-flash target model answering READ/PP/RDSR/WREN/WRDI from an
// internal byte array; quad read (0x6B) only when SPI_RESP_QUAD_EN is defined.
module spi_flash_responder #(
    parameter int MEM_AW      = 12,
    parameter int PAGE_AW     = 8,
    parameter int BUSY_CYCLES = 64
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic [3:0] dq_in,
    output logic [3:0] dq_out,
    output logic [3:0] dq_oe,
    output logic       wip,
    output logic       wel,
    output logic       cmd_err
);

    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LD = BW'(BUSY_CYCLES);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR,
`ifdef SPI_RESP_QUAD_EN
        DUMMY, RD_Q,
`endif
        RD_S, PROG, STATUS, IGNORE
    } state_t;

    state_t state, state_n;

    logic cs_m, cs_s, cs_q;
    logic sck_m, sck_s, sck_q;
    logic si_m, si;
    logic unused_dq;

    logic [6:0]        shreg;
    logic [7:0]        opc;
    logic [7:0]        opc_in;
    logic [4:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [7:0]        out_sr;
    logic [MEM_AW-1:0] addr;
    logic              prog_any;
    logic [BW-1:0]     busy_cnt;

    logic [7:0] mem [0:(1<<MEM_AW)-1];
    logic [7:0] rd_q;

    logic cs_rise, cs_fall, rise, fall;
    logic err_s, wel_set, wel_clr;
    logic mem_we, commit;

    assign unused_dq = ^dq_in[3:1];
    assign cs_rise = cs_s & ~cs_q;
    assign cs_fall = ~cs_s & cs_q;
    assign rise    = sck_s & ~sck_q;
    assign fall    = ~sck_s & sck_q;
    assign opc_in  = {shreg, si};
    assign mem_we  = (state == PROG) && rise && (bit_cnt[2:0] == 3'd7);
    assign commit  = cs_rise && (state == PROG) && prog_any;

    // Bring the SPI pins into the clk_50MHz domain and keep one-cycle history.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            cs_m  <= 1'b1;
            cs_s  <= 1'b1;
            cs_q  <= 1'b1;
            sck_m <= 1'b0;
            sck_s <= 1'b0;
            sck_q <= 1'b0;
            si_m  <= 1'b0;
            si    <= 1'b0;
        end else begin
            cs_m  <= spi_cs_n;
            cs_s  <= cs_m;
            cs_q  <= cs_s;
            sck_m <= spi_sclk;
            sck_s <= sck_m;
            sck_q <= sck_s;
            si_m  <= dq_in[0];
            si    <= si_m;
        end
    end

    // State register.
    always_ff @(posedge clk_50MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and opcode decode; cs_n rise overrides everything.
    always_comb begin
        state_n = state;
        err_s   = 1'b0;
        wel_set = 1'b0;
        wel_clr = 1'b0;
        unique case (state)
            IDLE: if (cs_fall) state_n = CMD;
            CMD: if (rise && bit_cnt == 5'd7) begin
                state_n = IGNORE;
                if (opc_in == 8'h05) begin
                    state_n = STATUS;
                end else if (wip) begin
                    err_s = 1'b1;
                end else begin
                    case (opc_in)
                        8'h06: wel_set = 1'b1;
                        8'h04: wel_clr = 1'b1;
                        8'h03: state_n = ADDR;
`ifdef SPI_RESP_QUAD_EN
                        8'h6B: state_n = ADDR;
`endif
                        8'h02: begin
                            if (wel) state_n = ADDR;
                            else     err_s = 1'b1;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
            end
            ADDR: if (rise && bit_cnt == 5'd23) begin
                case (opc)
                    8'h03:   state_n = RD_S;
`ifdef SPI_RESP_QUAD_EN
                    8'h6B:   state_n = DUMMY;
`endif
                    default: state_n = PROG;
                endcase
            end
`ifdef SPI_RESP_QUAD_EN
            DUMMY: if (rise && bit_cnt == 5'd7) state_n = RD_Q;
`endif
            default: ;
        endcase
        if (cs_rise) state_n = IDLE;
    end

    // Shift-in, address tracking and output drive on sclk edges.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            dq_out   <= 4'h0;
            dq_oe    <= 4'h0;
            cmd_err  <= 1'b0;
            shreg    <= 7'h0;
            opc      <= 8'h0;
            bit_cnt  <= 5'd0;
            out_cnt  <= 3'd0;
            out_sr   <= 8'h0;
            addr     <= '0;
            prog_any <= 1'b0;
        end else begin
            cmd_err <= err_s;
            if (rise) shreg <= opc_in[6:0];
            if (state == CMD && rise && bit_cnt == 5'd7) opc <= opc_in;
            if (cs_fall) prog_any <= 1'b0;
            if (state == ADDR && rise) addr <= {addr[MEM_AW-2:0], si};
            if (mem_we) begin
                addr     <= {addr[MEM_AW-1:PAGE_AW], addr[PAGE_AW-1:0] + 1'b1};
                prog_any <= 1'b1;
            end
            if (rise) bit_cnt <= bit_cnt + 1'b1;
            if (cs_rise) begin
                dq_oe  <= 4'h0;
                dq_out <= 4'h0;
            end else if (fall) begin
                out_cnt <= out_cnt + 1'b1;
                case (state)
                    RD_S: begin
                        dq_oe <= 4'b0010;
                        if (out_cnt == 3'd0) begin
                            dq_out <= {2'b00, rd_q[7], 1'b0};
                            out_sr <= {rd_q[6:0], 1'b0};
                            addr   <= addr + 1'b1;
                        end else begin
                            dq_out <= {2'b00, out_sr[7], 1'b0};
                            out_sr <= {out_sr[6:0], 1'b0};
                        end
                    end
                    STATUS: begin
                        dq_oe <= 4'b0010;
                        if (out_cnt == 3'd0) begin
                            dq_out <= 4'b0000;
                            out_sr <= {6'b0, wel, wip, 1'b0};
                        end else begin
                            dq_out <= {2'b00, out_sr[7], 1'b0};
                            out_sr <= {out_sr[6:0], 1'b0};
                        end
                    end
`ifdef SPI_RESP_QUAD_EN
                    RD_Q: begin
                        dq_oe <= 4'hF;
                        if (!out_cnt[0]) begin
                            dq_out      <= rd_q[7:4];
                            out_sr[3:0] <= rd_q[3:0];
                            addr        <= addr + 1'b1;
                        end else begin
                            dq_out <= out_sr[3:0];
                        end
                    end
`endif
                    default: ;
                endcase
            end
            if (state_n != state) begin
                bit_cnt <= 5'd0;
                out_cnt <= 3'd0;
            end
        end
    end

    // Write-in-progress timer and write-enable latch.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            busy_cnt <= '0;
            wip      <= 1'b0;
            wel      <= 1'b0;
        end else if (commit) begin
            busy_cnt <= BUSY_LD;
            wip      <= 1'b1;
            wel      <= 1'b0;
        end else begin
            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == BW'(1)) wip <= 1'b0;
            end
            if (wel_set)      wel <= 1'b1;
            else if (wel_clr) wel <= 1'b0;
        end
    end

    // Byte array: NOR-style AND on program, registered read of current address.
    always_ff @(posedge clk_50MHz) begin
        if (mem_we) mem[addr] <= rd_q & opc_in;
        rd_q <= mem[addr];
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder: opcode vector table, directed corner
// sequences and randomized READ/PP traffic against a byte-array model.
module tb_spi_flash_responder;

    localparam int MEM_AW  = 12;
    localparam int PAGE_AW = 8;
    localparam int BUSY    = 600;
    localparam int HALF    = 8;
    localparam int MSZ     = 1 << MEM_AW;
`ifdef SPI_RESP_QUAD_EN
    localparam logic QERR = 1'b0;
`else
    localparam logic QERR = 1'b1;
`endif

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       spi_cs_n  = 1'b1;
    logic       spi_sclk  = 1'b0;
    logic [3:0] dq_in     = 4'h0;
    logic [3:0] dq_out, dq_oe;
    logic       wip, wel, cmd_err;

    spi_flash_responder #(
        .MEM_AW(MEM_AW), .PAGE_AW(PAGE_AW), .BUSY_CYCLES(BUSY)
    ) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .wip(wip), .wel(wel), .cmd_err(cmd_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int n_chk = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic [3:0] oe_any;
    logic [3:0] oe_at_cs;
    logic [7:0] ref_mem [MSZ];

    always @(negedge clk_50MHz) if (cmd_err) err_cnt++;

    typedef struct {
        logic [7:0] op;
        logic       pre_wren;
        logic       exp_err;
        logic       exp_drive;
        logic       exp_wel;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic sbit(input logic [3:0] din, output logic [3:0] d);
        dq_in = din;
        tick(HALF);
        d = dq_out;
        oe_any = oe_any | dq_oe;
        spi_sclk = 1'b1;
        tick(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic cs_lo();
        oe_any = 4'h0;
        spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_hi();
        tick(4);
        spi_cs_n = 1'b1;
        tick(4);
        oe_at_cs = dq_oe;
        tick(HALF);
    endtask

    task automatic tx(input logic [7:0] b);
        logic [3:0] d;
        logic [7:0] s;
        s = b;
        for (int i = 0; i < 8; i++) begin
            sbit({3'b000, s[7]}, d);
            s = s << 1;
        end
    endtask

    task automatic rx(output logic [7:0] b);
        logic [3:0] d;
        b = 8'h0;
        for (int i = 0; i < 8; i++) begin
            sbit(4'h0, d);
            b = {b[6:0], d[1]};
        end
    endtask

    task automatic tx_addr(input logic [23:0] a);
        tx(a[23:16]);
        tx(a[15:8]);
        tx(a[7:0]);
    endtask

    task automatic cmd1(input logic [7:0] op);
        cs_lo();
        tx(op);
        cs_hi();
    endtask

    task automatic rdsr(output logic [7:0] s);
        cs_lo();
        tx(8'h05);
        rx(s);
        cs_hi();
    endtask

    task automatic rd_check(input logic [23:0] a, input int n, input string nm);
        logic [7:0] b;
        logic [MEM_AW-1:0] ix;
        ix = a[MEM_AW-1:0];
        cs_lo();
        tx(8'h03);
        tx_addr(a);
        for (int i = 0; i < n; i++) begin
            rx(b);
            chk(nm, 32'(b), 32'(ref_mem[ix]));
            ix = ix + 1'b1;
        end
        cs_hi();
    endtask

    initial begin
        logic [7:0]  s, b;
        logic [23:0] a, pa;
        logic [MEM_AW-1:0] ix;
        logic [15:0] q;
        logic [3:0]  d;
        int e0, n;

        for (int i = 0; i < MSZ; i++) begin
            dut.mem[12'(i)] <= 8'hFF;
            ref_mem[i] = 8'hFF;
        end
        dut.mem[12'h010] <= 8'hA5;
        dut.mem[12'h011] <= 8'h3C;
        dut.mem[12'hFFF] <= 8'h5A;
        ref_mem[12'h010] = 8'hA5;
        ref_mem[12'h011] = 8'h3C;
        ref_mem[12'hFFF] = 8'h5A;

        vt[0] = '{8'h9F, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h06, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2] = '{8'hAB, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{8'h04, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h6B, 1'b0, QERR, 1'b0, 1'b0};
        vt[7] = '{8'h20, 1'b1, 1'b1, 1'b0, 1'b1};

        tick(4);
        chk("rst_dq_out", 32'(dq_out), 32'h0);
        chk("rst_dq_oe", 32'(dq_oe), 32'h0);
        chk("rst_wip", 32'(wip), 32'h0);
        chk("rst_wel", 32'(wel), 32'h0);
        chk("rst_cmd_err", 32'(cmd_err), 32'h0);
        reset = 1'b0;
        tick(8);

        for (int k = 0; k < 8; k++) begin
            if (vt[k].pre_wren) cmd1(8'h06);
            e0 = err_cnt;
            cs_lo();
            tx(vt[k].op);
            tx(8'h00);
            tx(8'h00);
            chk($sformatf("vec%0d_err", k), 32'(err_cnt - e0), 32'(vt[k].exp_err));
            chk($sformatf("vec%0d_drive", k), 32'(oe_any != 4'h0), 32'(vt[k].exp_drive));
            cs_hi();
            chk($sformatf("vec%0d_oe_cs", k), 32'(oe_at_cs), 32'h0);
            chk($sformatf("vec%0d_wel", k), 32'(wel), 32'(vt[k].exp_wel));
        end

        cs_lo();
        tx(8'h03);
        tx_addr(24'h000010);
        rx(b);
        chk("read_b0", 32'(b), 32'hA5);
        chk("read_oe", 32'(oe_any), 32'h2);
        rx(b);
        chk("read_b1", 32'(b), 32'h3C);
        cs_hi();
        chk("read_oe_cs", 32'(oe_at_cs), 32'h0);

        cmd1(8'h06);
        chk("wren_wel", 32'(wel), 32'h1);
        cs_lo();
        tx(8'h02);
        tx_addr(24'h0000FF);
        tx(8'h0F);
        tx(8'hF0);
        cs_hi();
        ref_mem[12'h0FF] = ref_mem[12'h0FF] & 8'h0F;
        ref_mem[12'h000] = ref_mem[12'h000] & 8'hF0;
        rdsr(s);
        chk("pp_rdsr_busy", 32'(s), 32'h01);
        chk("pp_wel_clr", 32'(wel), 32'h0);
        tick(BUSY);
        rdsr(s);
        chk("pp_rdsr_done", 32'(s), 32'h00);
        cs_lo();
        tx(8'h03);
        tx_addr(24'h0000FF);
        rx(b);
        chk("pp_byte_ff", 32'(b), 32'h0F);
        cs_hi();
        cs_lo();
        tx(8'h03);
        tx_addr(24'h000000);
        rx(b);
        chk("pp_page_wrap", 32'(b), 32'hF0);
        cs_hi();

        e0 = err_cnt;
        cs_lo();
        tx(8'h02);
        tx_addr(24'h000020);
        tx(8'h00);
        cs_hi();
        chk("pp_nowren_err", 32'(err_cnt - e0), 32'h1);
        chk("pp_nowren_wip", 32'(wip), 32'h0);
        rd_check(24'h000020, 1, "pp_nowren_mem");

        cs_lo();
        tx(8'h03);
        tx_addr(24'h000FFF);
        rx(b);
        chk("wrap_b0", 32'(b), 32'h5A);
        rx(b);
        chk("wrap_b1", 32'(b), 32'hF0);
        cs_hi();

        e0 = err_cnt;
        cs_lo();
        tx(8'h03);
        tx(8'h00);
        cs_hi();
        cs_lo();
        tx(8'h03);
        tx_addr(24'h000010);
        rx(b);
        cs_hi();
        chk("abort_then_read", 32'(b), 32'hA5);
        chk("abort_no_err", 32'(err_cnt - e0), 32'h0);

`ifdef SPI_RESP_QUAD_EN
        cs_lo();
        tx(8'h6B);
        tx_addr(24'h000010);
        tx(8'h00);
        q = 16'hA53C;
        for (int k = 0; k < 4; k++) begin
            sbit(4'h0, d);
            chk($sformatf("quad_nib%0d", k), 32'(d), 32'(q[15:12]));
            q = q << 4;
        end
        chk("quad_oe", 32'(dq_oe), 32'hF);
        cs_hi();
        chk("quad_oe_cs", 32'(oe_at_cs), 32'h0);
`endif

        cmd1(8'h06);
        cs_lo();
        tx(8'h02);
        tx_addr(24'h000030);
        for (int i = 0; i < 4; i++) sbit(4'h0, d);
        chk("rstpp_wel_pre", 32'(wel), 32'h1);
        reset = 1'b1;
        tick(1);
        chk("rstpp_dq_out", 32'(dq_out), 32'h0);
        chk("rstpp_dq_oe", 32'(dq_oe), 32'h0);
        chk("rstpp_wip", 32'(wip), 32'h0);
        chk("rstpp_wel", 32'(wel), 32'h0);
        chk("rstpp_cmd_err", 32'(cmd_err), 32'h0);
        reset = 1'b0;
        cs_hi();
        rd_check(24'h000030, 1, "rstpp_mem");

        for (int r = 0; r < 20; r++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                rd_check(a, n, "rand_read");
            end else begin
                cmd1(8'h06);
                cs_lo();
                tx(8'h02);
                tx_addr(a);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    tx(b);
                    pa = a;
                    pa[PAGE_AW-1:0] = a[PAGE_AW-1:0] + 8'(i);
                    ix = pa[MEM_AW-1:0];
                    ref_mem[ix] = ref_mem[ix] & b;
                end
                cs_hi();
                chk("rand_pp_wip", 32'(wip), 32'h1);
                tick(BUSY + 20);
                for (int i = 0; i < n; i++) begin
                    pa = a;
                    pa[PAGE_AW-1:0] = a[PAGE_AW-1:0] + 8'(i);
                    rd_check(pa, 1, "rand_pp_verify");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR-flash target model; answers the SPI flash controller's command stream on the same pins (cs, sclk, 4-bit dq) from an internal byte array.
- Used in loopback builds and simulation in place of the physical flash, so controller read/program paths can be exercised without the configuration flash.
- All logic runs on clk_50MHz; SPI pins are oversampled, never used as clocks.

Parameters:
MEM_AW, 12, byte-address width of internal array (2^MEM_AW bytes); 24-bit SPI addresses are taken modulo 2^MEM_AW
PAGE_AW, 8, page size 2^PAGE_AW bytes; program addresses wrap within the page
BUSY_CYCLES, 64, clk_50MHz cycles that WIP stays 1 after a program ends

Ports:
clk_50MHz  in  1  system clock
reset  in  1  synchronous, active-high
spi_cs_n  in  1  chip select from controller, active-low
spi_sclk  in  1  SPI clock from controller, mode 0, at most clk_50MHz/8
dq_in  in  4  dq pins as driven by controller; dq_in[0] = SI
dq_out  out  4  responder drive values
dq_oe  out  4  per-bit output enable
wip  out  1  status bit0, write in progress
wel  out  1  status bit1, write enable latch
cmd_err  out  1  one-cycle pulse on unsupported or rejected opcode

Behaviour:
- Reset values: dq_out=0, dq_oe=0, wip=0, wel=0, cmd_err=0, state=IDLE, busy counter=0. Array contents are not cleared.
- Inputs pass through 2-FF synchronizers. sclk rise/fall are detected on the synced copies.
- Data is sampled on detected sclk rise. Outputs update on detected sclk fall, within 4 clk of the pin edge.
- A synced cs_n rise in any state goes to IDLE, sets dq_oe=0 and discards the partial byte. This is the only abort path.
- States: IDLE, CMD, ADDR, DUMMY, RD_S, RD_Q, PROG, STATUS, IGNORE.
- IDLE -> CMD on cs_n fall. CMD shifts 8 bits MSB-first from dq_in[0], then decodes:
  - 0x06 WREN: sets wel.
  - 0x04 WRDI: clears wel.
  - 0x05 RDSR -> STATUS: byte {6'b0, wel, wip} on dq_out[1] with dq_oe=4'b0010, MSB-first, repeated until cs_n rises. The byte is re-latched at each byte boundary, so live wip is visible.
  - 0x03 READ -> ADDR -> RD_S.
  - 0x6B QUAD READ -> ADDR -> DUMMY (8 sclk) -> RD_Q.
  - 0x02 PP -> ADDR -> PROG.
  - Any other opcode: cmd_err pulse, -> IGNORE.
- While wip=1, every opcode except 0x05 gives a cmd_err pulse and goes to IGNORE. PP with wel=0 does the same.
- ADDR: 24 bits MSB-first on dq_in[0]; the low MEM_AW bits are kept.
- RD_S: byte at addr on dq_out[1], MSB-first, dq_oe=4'b0010. The first bit is driven on the sclk fall after the last address bit. Address increments per byte and wraps 2^MEM_AW-1 -> 0.
- RD_Q: nibble per sclk, high nibble first, on dq_out[3:0], dq_oe=4'hF. The first nibble is driven on the fall after the 8th dummy sclk. Address increments and wraps as in RD_S.
- PROG: bytes MSB-first from dq_in[0].
  - Each completed byte does mem[addr] <= mem[addr] & byte (NOR semantics).
  - Only the low PAGE_AW address bits increment, so writes wrap within the page.
  - On cs_n rise after at least one completed byte: wip=1, wel=0, busy counter loads BUSY_CYCLES.
  - On cs_n rise with zero completed bytes: no state change.
- Busy counter decrements each clk. wip clears on the cycle the counter reaches 0.
- The busy counter keeps running across later transactions.
- The array has one synchronous write port and one read port; the read byte is fetched one byte-time ahead of use.

Optional Feature:
- SPI_RESP_QUAD_EN defined: 0x6B is supported as described above.
- Not defined: 0x6B is treated as an unknown opcode (cmd_err, IGNORE). dq_oe[3:2] and dq_out[3:2] are tied to 0, and the DUMMY and RD_Q states are removed.

Test Plan:
- Preload mem[0x010]=0xA5, 0x011=0x3C; READ 0x03 addr 0x000010, 16 sclk -> dq_out[1] serial 0xA5 then 0x3C, dq_oe=4'b0010, dq_oe=0 within 4 clk of cs_n rise.
- WREN; PP 0x02 addr 0x0000FF with data 0x0F,0xF0 over erased 0xFF -> mem[0x0FF]=0x0F, mem[0x000]=0xF0 (page wrap). RDSR immediately after -> 0x01 (wip=1, wel=0). After BUSY_CYCLES clk, RDSR -> 0x00.
- PP without prior WREN -> cmd_err pulse, array unchanged, wip stays 0.
- With quad enabled: QUAD READ 0x6B addr 0x000010, 8 dummy, 4 sclk -> nibbles A,5,3,C on dq_out, dq_oe=4'hF. With quad disabled -> cmd_err pulse, dq_oe=0.
- READ at addr 2^MEM_AW-1 for 2 bytes -> second byte is mem[0]. cs_n raised mid-address -> IDLE, next transaction decodes normally.
- Opcode 0x9F -> cmd_err high exactly 1 cycle, no dq drive until cs_n rise. Reset asserted mid-PP -> all outputs at reset values next cycle.
